// File: rtl/catalog_down_counter.sv
// catalog_down_counter: presettable synchronous down-counter with P/T enables,
// ripple-borrow output and a one-shot / auto-reload terminal-count FSM.
module catalog_down_counter #(
    parameter int WIDTH       = 4,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             P,
    input  logic             T,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] Qdata,
    output logic             RBO,
    output logic             DONE
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE_ST
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             done_q, done_d;
    logic             count_en;
    logic             at_zero;

    assign count_en = P & T & ~LOAD;
    assign at_zero  = (count_q == '0);

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        // Auto-reload DONE is a single-cycle pulse; one-shot DONE is sticky.
        done_d   = AUTO_RELOAD ? 1'b0 : done_q;

        unique case (1'b1)
            LOAD: begin
                count_d  = data;
                reload_d = data;
                done_d   = 1'b0;
                state_d  = RUN;
            end
            count_en: begin
                unique case (state_q)
                    IDLE: begin
                        count_d = count_q - WIDTH'(1);
                    end
                    RUN: begin
                        if (!at_zero) begin
                            count_d = count_q - WIDTH'(1);
                        end else if (AUTO_RELOAD) begin
                            count_d = reload_q;
                            done_d  = 1'b1;
                        end else begin
                            done_d  = 1'b1;
                            state_d = DONE_ST;
                        end
                    end
                    DONE_ST: begin
                        count_d = count_q;
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            done_q   <= done_d;
        end
    end

    assign Qdata = count_q;
    assign RBO   = T & at_zero;
    assign DONE  = done_q;

endmodule

// File: tb/tb_catalog_down_counter.sv
// tb_catalog_down_counter: directed stimulus with a queue scoreboard
// drained by an independent monitor after each clock edge.
module tb_catalog_down_counter;

    logic CLK = 1'b0;
    logic CLR = 1'b0;
    always #50 CLK = ~CLK;

    logic       p_a = 0, t_a = 1, ld_a = 0;
    logic [3:0] d_a = '0, q_a;
    logic       rbo_a, done_a;

    logic       p_b = 0, t_b = 0, ld_b = 0;
    logic [3:0] d_b = '0, q_b;
    logic       rbo_b, done_b;

    logic       p_c = 0, t_lo = 0, ld_lo = 0, ld_hi = 0;
    logic [3:0] d_lo = '0, d_hi = '0, q_lo, q_hi;
    logic       rbo_lo, rbo_hi, done_lo, done_hi;

    catalog_down_counter #(.WIDTH(4), .AUTO_RELOAD(1'b0)) u_os (
        .CLK(CLK), .CLR(CLR), .P(p_a), .T(t_a), .LOAD(ld_a),
        .data(d_a), .Qdata(q_a), .RBO(rbo_a), .DONE(done_a)
    );

    catalog_down_counter #(.WIDTH(4), .AUTO_RELOAD(1'b1)) u_ar (
        .CLK(CLK), .CLR(CLR), .P(p_b), .T(t_b), .LOAD(ld_b),
        .data(d_b), .Qdata(q_b), .RBO(rbo_b), .DONE(done_b)
    );

    catalog_down_counter #(.WIDTH(4), .AUTO_RELOAD(1'b0)) u_lo (
        .CLK(CLK), .CLR(CLR), .P(p_c), .T(t_lo), .LOAD(ld_lo),
        .data(d_lo), .Qdata(q_lo), .RBO(rbo_lo), .DONE(done_lo)
    );

    catalog_down_counter #(.WIDTH(4), .AUTO_RELOAD(1'b0)) u_hi (
        .CLK(CLK), .CLR(CLR), .P(p_c), .T(rbo_lo), .LOAD(ld_hi),
        .data(d_hi), .Qdata(q_hi), .RBO(rbo_hi), .DONE(done_hi)
    );

    typedef struct {
        int       which;
        int       tag;
        logic [7:0] q;
        logic     done;
        logic     rbo;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    event chk_ev;

    function automatic void push_exp(int w, int tag, int q, bit d, bit r);
        exp_t e;
        e.which = w;
        e.tag   = tag;
        e.q     = 8'(q);
        e.done  = d;
        e.rbo   = r;
        sb.push_back(e);
    endfunction

    // Monitor: drains every expectation queued for the edge just taken.
    initial begin
        exp_t       e;
        logic [7:0] aq;
        logic       ad, ar;
        forever begin
            @(posedge CLK or chk_ev);
            #1;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                case (e.which)
                    0: begin aq = {4'h0, q_a}; ad = done_a; ar = rbo_a; end
                    1: begin aq = {4'h0, q_b}; ad = done_b; ar = rbo_b; end
                    default: begin
                        aq = {q_hi, q_lo};
                        ad = done_hi | done_lo;
                        ar = rbo_hi;
                    end
                endcase
                checks++;
                if (aq !== e.q || ad !== e.done || ar !== e.rbo) begin
                    errors++;
                    $display("FAIL t%0d dut%0d q=%0d exp %0d done=%b exp %b rbo=%b exp %b",
                             e.tag, e.which, aq, e.q, ad, e.done, ar, e.rbo);
                end
            end
        end
    end

    task automatic step_a(bit p, bit t, bit ld, int d);
        @(negedge CLK);
        p_a = p; t_a = t; ld_a = ld; d_a = 4'(d);
    endtask

    task automatic step_b(bit p, bit t, bit ld, int d);
        @(negedge CLK);
        p_b = p; t_b = t; ld_b = ld; d_b = 4'(d);
    endtask

    int os_q[3]  = '{2, 1, 0};
    int ar_q[15] = '{3, 2, 1, 0, 4, 3, 2, 1, 0, 4, 3, 2, 1, 0, 4};

    initial begin
        // Reset state
        #10;
        push_exp(0, 0, 0, 0, 1);
        push_exp(1, 0, 0, 0, 0);
        push_exp(2, 0, 0, 0, 0);
        ->chk_ev;

        // 1: IDLE wrap
        step_a(1, 1, 0, 0);
        CLR = 1'b1;
        push_exp(0, 1, 15, 0, 0);
        step_a(1, 1, 0, 0); push_exp(0, 1, 14, 0, 0);
        step_a(1, 1, 0, 0); push_exp(0, 1, 13, 0, 0);

        // 2: one-shot terminal
        step_a(1, 1, 1, 3); push_exp(0, 2, 3, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step_a(1, 1, 0, 0);
            push_exp(0, 2, os_q[i], 0, os_q[i] == 0);
        end
        for (int i = 0; i < 6; i++) begin
            step_a(1, 1, 0, 0); push_exp(0, 2, 0, 1, 1);
        end
        step_a(1, 1, 1, 2); push_exp(0, 2, 2, 0, 0);

        // 4: enables and priority
        step_a(1, 1, 1, 9); push_exp(0, 4, 9, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step_a(0, 1, 0, 0); push_exp(0, 4, 9, 0, 0);
        end
        for (int i = 0; i < 3; i++) begin
            step_a(1, 0, 0, 0); push_exp(0, 4, 9, 0, 0);
        end
        step_a(0, 1, 1, 0);  push_exp(0, 4, 0, 0, 1);
        step_a(0, 0, 0, 0);  push_exp(0, 4, 0, 0, 0);
        step_a(1, 1, 1, 14); push_exp(0, 4, 14, 0, 0);

        // 5: async reset mid-count
        step_a(1, 1, 1, 7); push_exp(0, 5, 7, 0, 0);
        step_a(1, 1, 0, 0); push_exp(0, 5, 6, 0, 0);
        step_a(1, 1, 0, 0); push_exp(0, 5, 5, 0, 0);
        @(negedge CLK);
        #10 CLR = 1'b0;
        #5;
        push_exp(0, 5, 0, 0, 1);
        ->chk_ev;
        step_a(1, 1, 0, 0);
        CLR = 1'b1;
        push_exp(0, 5, 15, 0, 0);
        step_a(1, 1, 0, 0); push_exp(0, 5, 14, 0, 0);
        step_a(0, 0, 0, 0);

        // 3: auto-reload divider
        step_b(1, 1, 1, 4); push_exp(1, 3, 4, 0, 0);
        for (int i = 0; i < 15; i++) begin
            step_b(1, 1, 0, 0);
            push_exp(1, 3, ar_q[i], ar_q[i] == 4, ar_q[i] == 0);
        end
        step_b(0, 1, 0, 0); push_exp(1, 3, 4, 0, 0);
        step_b(0, 1, 1, 0); push_exp(1, 3, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step_b(1, 1, 0, 0); push_exp(1, 3, 0, 1, 1);
        end
        step_b(0, 0, 0, 0);

        // 6: two-digit cascade, low digit left in IDLE at 0
        @(negedge CLK);
        ld_hi = 1; d_hi = 4'd1; p_c = 0; t_lo = 1;
        push_exp(2, 6, 8'h10, 0, 0);
        @(negedge CLK);
        ld_hi = 0; p_c = 1;
        push_exp(2, 6, 15, 0, 0);
        for (int i = 1; i < 16; i++) begin
            @(negedge CLK);
            push_exp(2, 6, 15 - i, 0, i == 15);
        end
        @(negedge CLK);
        push_exp(2, 6, 15, 1, 0);
        @(negedge CLK);
        p_c = 0;

        repeat (3) @(posedge CLK);
        #5;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d exp 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
